// File: rtl/safe_reset_sequencer.sv
// Safety-island reset sequencer: waits for a stable safety clock, releases domain
// resets one by one, re-asserts them on clock faults or software request, and escalates to a sticky FAULT.
module safe_reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int STAGE_DLY      = 16,
  parameter int STABLE_TIMEOUT = 1024,
  parameter int FAULT_LIMIT    = 3
) (
  input  logic                   clk_safety_i,
  input  logic                   rst_n_safety_i,
  input  logic                   clk_stable_i,
  input  logic                   clk_fault_i,
  input  logic                   sw_rst_req_i,
  input  logic                   fault_clr_i,
  output logic [NUM_DOMAINS-1:0] rst_n_domain_o,
  output logic                   seq_busy_o,
  output logic [2:0]             seq_state_o,
  output logic                   safety_error_o,
  output logic [31:0]            safety_error_code_o
);

  localparam int TMAX = (STABLE_TIMEOUT > STAGE_DLY) ? STABLE_TIMEOUT : STAGE_DLY;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int IW   = $clog2(NUM_DOMAINS) + 1;
  localparam int FW   = $clog2(FAULT_LIMIT + 1);

  localparam logic [TW-1:0]          STAGE_END   = TW'(STAGE_DLY - 1);
  localparam logic [TW-1:0]          STABLE_END  = TW'(STABLE_TIMEOUT - 1);
  localparam logic [IW-1:0]          LAST_IDX    = IW'(NUM_DOMAINS - 1);
  localparam logic [FW-1:0]          FAULT_LIM_W = FW'(FAULT_LIMIT);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE     = NUM_DOMAINS'(1);
  localparam logic [31:0]            CODE_CLK_TIMEOUT = 32'hC001_0011;
  localparam logic [31:0]            CODE_FAULT_LIMIT = 32'hC001_0013;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CLK = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_RUN      = 3'd3,
    ST_ASSERT   = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [FW-1:0]          fault_cnt_q, fault_cnt_d, fault_cnt_inc;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic [31:0]            code_q, code_d;
  logic                   busy_q, err_q;
  logic                   clk_bad;

  assign clk_bad       = clk_fault_i || !clk_stable_i;
  assign fault_cnt_inc = (fault_cnt_q < FAULT_LIM_W) ? fault_cnt_q + 1'b1 : fault_cnt_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    idx_d       = idx_q;
    fault_cnt_d = fault_cnt_q;
    dom_d       = dom_q;
    code_d      = code_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_WAIT_CLK;
      ST_WAIT_CLK: begin
        if (clk_stable_i) begin
          state_d = ST_RELEASE;
          idx_d   = '0;
        end else if (timer_q == STABLE_END) begin
          state_d = ST_FAULT;
          code_d  = CODE_CLK_TIMEOUT;
        end
      end
      ST_RELEASE: begin
        // A clock problem wins over a release scheduled for the same edge.
        if (clk_bad) begin
          state_d     = ST_ASSERT;
          fault_cnt_d = fault_cnt_inc;
          dom_d       = '0;
        end else if (timer_q == STAGE_END) begin
          dom_d   = dom_q | (DOM_ONE << idx_q);
          idx_d   = idx_q + 1'b1;
          timer_d = '0;
          if (idx_q == LAST_IDX) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clk_bad) begin
          state_d     = ST_ASSERT;
          fault_cnt_d = fault_cnt_inc;
          dom_d       = '0;
        end else if (sw_rst_req_i) begin
          state_d = ST_ASSERT;
          dom_d   = '0;
        end
      end
      ST_ASSERT: begin
        dom_d = '0;
        if (timer_q >= STAGE_END) begin
          timer_d = STAGE_END;
          if (fault_cnt_q >= FAULT_LIM_W) begin
            state_d = ST_FAULT;
            code_d  = CODE_FAULT_LIMIT;
          end else if (!sw_rst_req_i) begin
            state_d = ST_WAIT_CLK;
          end
        end
      end
      ST_FAULT: begin
        dom_d = '0;
        if (fault_clr_i) begin
          state_d     = ST_WAIT_CLK;
          fault_cnt_d = '0;
          code_d      = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dom_d   = '0;
      end
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk_safety_i or negedge rst_n_safety_i) begin
    if (!rst_n_safety_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      fault_cnt_q <= '0;
      dom_q       <= '0;
      code_q      <= '0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      fault_cnt_q <= fault_cnt_d;
      dom_q       <= dom_d;
      code_q      <= code_d;
      busy_q      <= (state_d != ST_RUN);
      err_q       <= (state_d == ST_FAULT);
    end
  end

  assign rst_n_domain_o      = dom_q;
  assign seq_busy_o          = busy_q;
  assign seq_state_o         = state_q;
  assign safety_error_o      = err_q;
  assign safety_error_code_o = code_q;

endmodule
